// File: rtl/pw_conv_engine.sv
// Pointwise/KxK convolution engine: streams IFM taps against a ROM,
// accumulates DSP_NO lanes, requantises and reports layer completion.
// Ports: clk/rst, en_i, ifm_* stream, w_addr_o/w_data_i ROM, bias_i,
//   ofm_o/ofm_valid_o/pix_idx_o, layer_done_o, ram_feedback_i, finish_o.
module pw_conv_engine #(
  parameter int WIDTH      = 16,
  parameter int DSP_NO     = 32,
  parameter int CHIN       = 128,
  parameter int KERNEL_DIM = 1,
  parameter int WOUT       = 32,
  parameter int FRAC       = 14,
  parameter int ROM_LAT    = 1,
  parameter int RELU_EN    = 1,
  localparam int N  = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int P  = WOUT * WOUT,
  localparam int NW = (N > 1) ? $clog2(N) : 1,
  localparam int PW = $clog2(P) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [WIDTH-1:0]           ifm_i,
  input  logic                       ifm_valid_i,
  output logic                       ifm_ready_o,
  output logic [NW-1:0]              w_addr_o,
  input  logic [DSP_NO*WIDTH-1:0]    w_data_i,
  input  logic [DSP_NO*2*WIDTH-1:0]  bias_i,
  output logic [DSP_NO*WIDTH-1:0]    ofm_o,
  output logic                       ofm_valid_o,
  output logic [PW-1:0]              pix_idx_o,
  output logic                       layer_done_o,
  input  logic                       ram_feedback_i,
  output logic                       finish_o
);

  localparam int A  = 2 * WIDTH + $clog2(N);
  localparam int SW = A + 1;
  localparam int BW = 2 * WIDTH;

  localparam logic signed [SW-1:0] QMAX =
    SW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] QMIN = -QMAX - SW'(1);
  localparam logic signed [SW-1:0] RND =
    (FRAC > 0) ? SW'(64'sd1 <<< ((FRAC > 0) ? FRAC - 1 : 0))
               : SW'(0);

  typedef enum logic [2:0] {
    IDLE, RUN, HOLD, DRAIN, DONE
  } state_t;

  typedef struct packed {
    logic             vld;
    logic             first;
    logic             last;
    logic [WIDTH-1:0] x;
  } beat_t;

  state_t state_q, state_d;

  logic [NW-1:0] t_q, t_d;
  logic [PW-1:0] in_pix_q, in_pix_d;
  logic [PW-1:0] out_cnt_q, out_cnt_d;
  logic          sticky_q, sticky_d;
  logic          last_q, last_d;

  logic [DSP_NO*WIDTH-1:0] ofm_q, ofm_d;
  logic                    ofm_valid_q, ofm_valid_d;
  logic [PW-1:0]           pix_idx_q, pix_idx_d;
  logic                    done_q, done_d;

  logic signed [A-1:0]       acc_q [DSP_NO];
  logic signed [A-1:0]       acc_d [DSP_NO];
  logic signed [2*WIDTH-1:0] prod  [DSP_NO];
  logic signed [SW-1:0]      sum_s [DSP_NO];
  logic signed [SW-1:0]      rnd_r [DSP_NO];
  logic [DSP_NO*WIDTH-1:0]   q_vec;

  logic  accept;
  logic  tap_last;
  logic  pix_last;
  logic  out_last;
  beat_t beat_in;
  beat_t mac_b;

  assign accept   = ifm_valid_i && (state_q == RUN);
  assign tap_last = (t_q == NW'(N - 1));
  assign pix_last = (in_pix_q == PW'(P - 1));
  assign out_last = (out_cnt_q == PW'(P - 1));

  assign beat_in.vld   = accept;
  assign beat_in.first = (t_q == '0);
  assign beat_in.last  = tap_last;
  assign beat_in.x     = ifm_i;

  // The sample delay line runs every cycle with a valid tag, so
  // in-flight taps always meet the weight the ROM returns for them,
  // even across stalls and HOLD.
  generate
    if (ROM_LAT == 0) begin : g_nolat
      assign mac_b = beat_in;
    end else begin : g_lat
      beat_t pipe_q [ROM_LAT];
      beat_t pipe_d [ROM_LAT];

      always_comb begin
        pipe_d[0] = beat_in;
        for (int i = 1; i < ROM_LAT; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < ROM_LAT; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < ROM_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
          end
        end
      end

      assign mac_b = pipe_q[ROM_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en_i) state_d = RUN;
      RUN: begin
        if (accept && tap_last && pix_last) state_d = DRAIN;
        else if (!en_i)                     state_d = HOLD;
      end
      HOLD:  if (en_i)   state_d = RUN;
      DRAIN: if (done_q) state_d = DONE;
      DONE:  if (!en_i)  state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    t_d      = t_q;
    in_pix_d = in_pix_q;
    if (accept) begin
      if (tap_last) begin
        t_d      = '0;
        in_pix_d = pix_last ? '0 : in_pix_q + 1'b1;
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (state_q != IDLE && ram_feedback_i) sticky_d = 1'b1;
    if (state_q == DONE && !en_i)          sticky_d = 1'b0;
  end

  // Tap 0 loads the product directly so pixels run back to back.
  always_comb begin
    for (int i = 0; i < DSP_NO; i++) begin
      prod[i] = $signed(mac_b.x) *
                $signed(w_data_i[i*WIDTH +: WIDTH]);
      acc_d[i] = acc_q[i];
      if (mac_b.vld) begin
        if (mac_b.first) acc_d[i] = A'(prod[i]);
        else             acc_d[i] = acc_q[i] + A'(prod[i]);
      end
    end
    last_d = mac_b.vld && mac_b.last;
  end

  always_comb begin
    q_vec = '0;
    for (int i = 0; i < DSP_NO; i++) begin
      sum_s[i] = SW'(acc_q[i]) +
                 SW'($signed(bias_i[i*BW +: BW]));
      rnd_r[i] = (sum_s[i] + RND) >>> FRAC;
      if (rnd_r[i] > QMAX) begin
        q_vec[i*WIDTH +: WIDTH] = QMAX[WIDTH-1:0];
      end else if (rnd_r[i] < QMIN) begin
        q_vec[i*WIDTH +: WIDTH] = QMIN[WIDTH-1:0];
      end else begin
        q_vec[i*WIDTH +: WIDTH] = rnd_r[i][WIDTH-1:0];
      end
      if (RELU_EN != 0 && rnd_r[i] < 0) begin
        q_vec[i*WIDTH +: WIDTH] = '0;
      end
    end
  end

  always_comb begin
    ofm_d       = ofm_q;
    pix_idx_d   = pix_idx_q;
    out_cnt_d   = out_cnt_q;
    ofm_valid_d = 1'b0;
    done_d      = 1'b0;
    if (last_q) begin
      ofm_d       = q_vec;
      pix_idx_d   = out_cnt_q;
      out_cnt_d   = out_last ? '0 : out_cnt_q + 1'b1;
      ofm_valid_d = 1'b1;
      done_d      = out_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      in_pix_q    <= '0;
      out_cnt_q   <= '0;
      sticky_q    <= 1'b0;
      last_q      <= 1'b0;
      ofm_q       <= '0;
      ofm_valid_q <= 1'b0;
      pix_idx_q   <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < DSP_NO; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      in_pix_q    <= in_pix_d;
      out_cnt_q   <= out_cnt_d;
      sticky_q    <= sticky_d;
      last_q      <= last_d;
      ofm_q       <= ofm_d;
      ofm_valid_q <= ofm_valid_d;
      pix_idx_q   <= pix_idx_d;
      done_q      <= done_d;
      for (int i = 0; i < DSP_NO; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign ifm_ready_o  = (state_q == RUN);
  assign w_addr_o     = t_q;
  assign ofm_o        = ofm_q;
  assign ofm_valid_o  = ofm_valid_q;
  assign pix_idx_o    = pix_idx_q;
  assign layer_done_o = done_q;
  assign finish_o     = (state_q == DONE) && !sticky_q;

endmodule
